// File: rtl/arch_regfile_param.sv
// rtl/arch_regfile_param.sv - parameterized architectural register file with per-register ready scoreboard
// Registered multi-port reads with write-back bypass, hold/flush pipeline control and source-ready detection.
module arch_regfile_param #(
   parameter  int XLEN     = 32,
   parameter  int NUM_REGS = 32,
   parameter  int NUM_RD   = 2,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_RD-1:0]      rd_en,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   output logic [NUM_RD-1:0]      rd_valid,
   input  logic                   wb_en,
   input  logic [AW-1:0]          wb_addr,
   input  logic [XLEN-1:0]        wb_data,
   input  logic                   inv_en,
   input  logic [AW-1:0]          inv_addr,
   input  logic                   uop_valid,
   input  logic                   hold,
   input  logic                   flush,
   output logic                   source_not_ready
);

   logic [NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]           valid_q, valid_d;
   logic [NUM_RD-1:0][XLEN-1:0]   rd_data_q, rd_data_d;
   logic [NUM_RD-1:0]             rd_valid_q, rd_valid_d;
   logic [NUM_RD-1:0]             rd_en_q, rd_en_d;
   logic                          uop_valid_q, uop_valid_d;
   logic                          wb_hit, inv_hit;

   assign wb_hit  = wb_en && (wb_addr != '0);
   assign inv_hit = inv_en && (inv_addr != '0);

   // Priority: write sets ready, invalidation clears it, flush overrides both.
   always_comb begin
      regs_d  = regs_q;
      valid_d = valid_q;
      if (wb_hit) begin
         regs_d[wb_addr]  = wb_data;
         valid_d[wb_addr] = 1'b1;
      end
      if (inv_hit) begin
         valid_d[inv_addr] = 1'b0;
      end
      if (flush) begin
         valid_d = '1;
      end
      regs_d[0]  = '0;
      valid_d[0] = 1'b1;
   end

   always_comb begin
      rd_data_d   = rd_data_q;
      rd_valid_d  = rd_valid_q;
      rd_en_d     = rd_en_q;
      uop_valid_d = uop_valid_q;
      if (!hold) begin
         rd_en_d     = rd_en;
         uop_valid_d = uop_valid;
         for (int i = 0; i < NUM_RD; i++) begin
            if (!rd_en[i]) begin
               rd_valid_d[i] = 1'b0;
            end else if (wb_hit && (wb_addr == rd_addr[i*AW +: AW])) begin
               rd_data_d[i]  = wb_data;
               rd_valid_d[i] = 1'b1;
            end else begin
               rd_data_d[i]  = regs_q[rd_addr[i*AW +: AW]];
               rd_valid_d[i] = valid_q[rd_addr[i*AW +: AW]];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q      <= '0;
         valid_q     <= '1;
         rd_data_q   <= '0;
         rd_valid_q  <= '0;
         rd_en_q     <= '0;
         uop_valid_q <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         valid_q     <= valid_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         rd_en_q     <= rd_en_d;
         uop_valid_q <= uop_valid_d;
      end
   end

   assign rd_data          = rd_data_q;
   assign rd_valid         = rd_valid_q;
   assign source_not_ready = uop_valid_q && (|(rd_en_q & ~rd_valid_q));

endmodule

// File: tb/tb_arch_regfile_param.sv
// tb/tb_arch_regfile_param.sv - self-checking bench for arch_regfile_param
// Directed scenarios plus random traffic against a behavioural register/scoreboard model.
module tb_arch_regfile_param;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  rd_en = '0;
   logic [9:0]  rd_addr = '0;
   logic [63:0] rd_data;
   logic [1:0]  rd_valid;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        inv_en = 1'b0;
   logic [4:0]  inv_addr = '0;
   logic        uop_valid = 1'b0;
   logic        hold = 1'b0;
   logic        flush = 1'b0;
   logic        source_not_ready;

   int tests = 0;
   int fails = 0;

   logic [31:0] m_regs [32];
   logic        m_val  [32];
   logic [31:0] m_rd   [2];
   logic        m_rv   [2];
   logic        m_en_q [2];
   logic        m_uop_q;

   arch_regfile_param #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2)) dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .inv_en(inv_en), .inv_addr(inv_addr), .uop_valid(uop_valid),
      .hold(hold), .flush(flush), .source_not_ready(source_not_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = '0;
         m_val[r]  = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
         m_rd[p]   = '0;
         m_rv[p]   = 1'b0;
         m_en_q[p] = 1'b0;
      end
      m_uop_q = 1'b0;
   endtask

   task automatic check_all(input string tag);
      logic exp_snr;
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("%s_data%0d", tag, p), rd_data[p*32 +: 32], m_rd[p]);
         chk($sformatf("%s_valid%0d", tag, p), {31'b0, rd_valid[p]}, {31'b0, m_rv[p]});
      end
      exp_snr = m_uop_q && ((m_en_q[0] && !m_rv[0]) || (m_en_q[1] && !m_rv[1]));
      chk({tag, "_snr"}, {31'b0, source_not_ready}, {31'b0, exp_snr});
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, check 1 time unit later.
   task automatic step(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia,
                       input logic uv, input logic h, input logic fl, input string tag);
      logic [4:0] addr;
      rd_en = en; rd_addr = {a1, a0};
      wb_en = we; wb_addr = wa; wb_data = wd;
      inv_en = ie; inv_addr = ia;
      uop_valid = uv; hold = h; flush = fl;
      @(posedge clk);
      if (!h) begin
         for (int p = 0; p < 2; p++) begin
            addr = (p == 0) ? a0 : a1;
            if (!en[p]) begin
               m_rv[p] = 1'b0;
            end else if (we && wa != 0 && wa == addr) begin
               m_rd[p] = wd;
               m_rv[p] = 1'b1;
            end else begin
               m_rd[p] = (addr == 0) ? 32'h0 : m_regs[addr];
               m_rv[p] = (addr == 0) ? 1'b1 : m_val[addr];
            end
            m_en_q[p] = en[p];
         end
         m_uop_q = uv;
      end
      if (we && wa != 0) begin
         m_regs[wa] = wd;
         m_val[wa]  = 1'b1;
      end
      if (ie && ia != 0) m_val[ia] = 1'b0;
      if (fl) for (int r = 0; r < 32; r++) m_val[r] = 1'b1;
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [63:0] snap_d;
      logic [1:0]  snap_v;
      logic        snap_s;
      model_reset();

      #2;
      chk("rst_data", rd_data[31:0], 32'h0);
      chk("rst_data1", rd_data[63:32], 32'h0);
      chk("rst_valid", {30'b0, rd_valid}, 32'h0);
      chk("rst_snr", {31'b0, source_not_ready}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      step(2'b11, 5'd1, 5'd2, 0, 0, 0, 0, 0, 1, 0, 0, "first_edge");
      chk("first_edge_snr", {31'b0, source_not_ready}, 32'h0);

      step(2'b00, 0, 0, 1, 5'd5, 32'hA5A5_0001, 0, 0, 0, 0, 0, "wr5");
      step(2'b01, 5'd5, 0, 0, 0, 0, 0, 0, 1, 0, 0, "rd5");
      chk("rd5_lit", rd_data[31:0], 32'hA5A5_0001);
      chk("rd5_vlit", {31'b0, rd_valid[0]}, 32'h1);

      step(2'b10, 0, 5'd7, 1, 5'd7, 32'h1234, 0, 0, 1, 0, 0, "byp7");
      chk("byp7_lit", rd_data[63:32], 32'h1234);
      chk("byp7_snr", {31'b0, source_not_ready}, 32'h0);

      step(2'b00, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0, 0, "inv3");
      step(2'b01, 5'd3, 0, 0, 0, 0, 0, 0, 1, 0, 0, "rd3_inv");
      chk("rd3_snr_lit", {31'b0, source_not_ready}, 32'h1);
      step(2'b00, 0, 0, 1, 5'd3, 32'h55, 0, 0, 0, 0, 0, "wb3");
      step(2'b01, 5'd3, 0, 0, 0, 0, 0, 0, 1, 0, 0, "rd3_ok");
      chk("rd3_ok_lit", {31'b0, rd_valid[0]}, 32'h1);

      step(2'b00, 0, 0, 1, 5'd9, 32'hFF, 1, 5'd9, 0, 0, 0, "wbinv9");
      step(2'b01, 5'd9, 0, 0, 0, 0, 0, 0, 1, 0, 0, "rd9");
      chk("rd9_lit", rd_data[31:0], 32'hFF);
      chk("rd9_vlit", {31'b0, rd_valid[0]}, 32'h0);

      step(2'b00, 0, 0, 1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0, "wr0");
      step(2'b00, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0, 0, "inv0");
      step(2'b11, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, "rd0");
      chk("rd0_lit", rd_data[31:0], 32'h0);

      step(2'b00, 0, 0, 0, 0, 0, 1, 5'd2, 0, 0, 0, "inv2");
      step(2'b00, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0, 0, "inv4");
      step(2'b00, 0, 0, 0, 0, 0, 1, 5'd6, 0, 0, 1, "flush");
      step(2'b11, 5'd2, 5'd4, 1, 5'd2, 32'hCAFE_0002, 0, 0, 1, 0, 0, "rd24");
      chk("rd24_vlit", {30'b0, rd_valid}, 32'h3);
      snap_d = rd_data; snap_v = rd_valid; snap_s = source_not_ready;
      for (int k = 0; k < 3; k++) begin
         step(2'($urandom), 5'($urandom), 5'($urandom), 1, 5'd11 + 5'(k), $urandom,
              0, 0, 1, 1, 0, "hold");
         chk("hold_d0", rd_data[31:0], snap_d[31:0]);
         chk("hold_d1", rd_data[63:32], snap_d[63:32]);
         chk("hold_v", {30'b0, rd_valid}, {30'b0, snap_v});
         chk("hold_s", {31'b0, source_not_ready}, {31'b0, snap_s});
      end

      for (int n = 0; n < 400; n++) begin
         step(2'($urandom), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
              ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 6) == 0),
              ($urandom_range(0, 19) == 0), "rand");
      end

      step(2'b00, 0, 0, 1, 5'd6, 32'h6666_6666, 0, 0, 0, 0, 0, "pre_rst");
      wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h7777_7777;
      inv_en = 1'b1; inv_addr = 5'd12;
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all("mid_rst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      step(2'b11, 5'd6, 5'd12, 0, 0, 0, 0, 0, 1, 0, 0, "post_rst");
      chk("post_rst_lit", rd_data[31:0], 32'h0);
      chk("post_rst_vlit", {30'b0, rd_valid}, 32'h3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/arch_regfile_param.md
ARCH_REGFILE_PARAM -- requirements
Module: arch_regfile_param

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: architectural register count (power of 2, >= 8).
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports (1..4).
REQ-004 SHALL derive AW = log2(NUM_REGS) as a localparam; AW SHALL NOT be overridable.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port rd_en, input, NUM_RD: per-port read request.
REQ-008 SHALL have port rd_addr, input, NUM_RD*AW: packed read addresses, port i at bits [i*AW +: AW].
REQ-009 SHALL have port rd_data, output, NUM_RD*XLEN: packed registered read data.
REQ-010 SHALL have port rd_valid, output, NUM_RD: per-port registered operand-ready flag.
REQ-011 SHALL have port wb_en / wb_addr / wb_data, inputs, 1 / AW / XLEN: write-back port.
REQ-012 SHALL have port inv_en / inv_addr, inputs, 1 / AW: destination invalidation (scoreboard) port.
REQ-013 SHALL have port uop_valid, input, 1: a valid micro-op is presenting its reads this cycle.
REQ-014 SHALL have port hold, input, 1: pipeline stall; freezes the read-side output registers.
REQ-015 SHALL have port flush, input, 1: pipeline flush; marks all registers ready.
REQ-016 SHALL have port source_not_ready, output, 1: the registered uop has at least one unready source.

Function
REQ-017 SHALL keep register 0 hardwired: reads return 0, valid always 1, writes and invalidations to it ignored.
REQ-018 SHALL give a read latency of 1 cycle: with rd_en[i]=1 and hold=0, rd_data[i] and rd_valid[i] update at the next edge from the array value and valid bit.
REQ-019 SHALL, with rd_en[i]=0 and hold=0, keep rd_data[i] unchanged and clear rd_valid[i] to 0.
REQ-020 SHALL bypass: if wb_en=1, wb_addr!=0 and wb_addr==rd_addr[i] with rd_en[i]=1, capture wb_data into rd_data[i] and set rd_valid[i]=1 (no stall).
REQ-021 SHALL, on wb_en=1 with wb_addr!=0, write wb_data to the array and set that valid bit.
REQ-022 SHALL, on inv_en=1 with inv_addr!=0, clear that valid bit at the next edge; reads in the same cycle see the pre-clear valid bit.
REQ-023 SHALL, when wb and inv target the same nonzero address in one cycle, write the data and leave the valid bit 0 (invalidation wins).
REQ-024 SHALL, on flush=1, set every valid bit to 1 at the next edge, overriding any same-cycle inv_en; wb data is still written.
REQ-025 SHALL, on hold=1, freeze rd_data, rd_valid, the registered rd_en and the registered uop_valid; array writes, invalidations and flush still take effect.
REQ-026 SHALL register rd_en and uop_valid alongside the read data (rd_en_q, uop_valid_q).
REQ-027 SHALL drive source_not_ready = uop_valid_q AND OR over i of (rd_en_q[i] AND NOT rd_valid[i]), combinationally from registered state only.
REQ-028 SHALL serve all NUM_RD ports independently and identically, including same-address reads on several ports in one cycle.

Reset
REQ-029 SHALL, while reset=0, asynchronously clear all array registers, rd_data, rd_valid, rd_en_q and uop_valid_q to 0, and set all valid bits to 1.
REQ-030 SHALL drive source_not_ready=0 during reset and on the first edge after release.
REQ-031 SHALL abandon an in-flight write or invalidation when reset asserts mid-cycle; no partial update survives.

Verification
REQ-032 SHALL pass this test: write reg 5=0xA5A5_0001, next cycle read port0 addr 5 -> one cycle later rd_data[0]=0xA5A5_0001 and rd_valid[0]=1.
REQ-033 SHALL pass this test: wb reg 7=0x1234 in the same cycle as a port1 read of 7 -> rd_data[1]=0x1234, rd_valid[1]=1, source_not_ready=0.
REQ-034 SHALL pass this test: inv 3, then uop_valid with a read of 3 -> rd_valid=0, source_not_ready=1; then wb 3=0x55 -> the next read gives valid=1.
REQ-035 SHALL pass this test: wb and inv of reg 9 in the same cycle with data 0xFF -> the array holds 0xFF and a read gives rd_valid=0.
REQ-036 SHALL pass this test: write reg 0=0xDEAD, inv 0, then read 0 -> rd_data=0, rd_valid=1.
REQ-037 SHALL pass this test: inv regs 2,4 then flush -> reads of 2,4 give valid=1; hold=1 for 3 cycles with changing addresses -> outputs stay constant.
